tap_period_avg: RTL and testbench

Second-generation tap-period measurement block for the TapTempo datapath. It counts time-base pulses (tp_i) between rising edges of the debounced button. It rejects taps that come too fast and times out when taps are too slow. It outputs a moving average of the last AVG_DEPTH intervals over a valid/ready handshake, and sits between the debouncer and the BPM divider.

---
 rtl/taptempo_pkg.sv | 27 ++
 rtl/tap_avg_ring.sv | 74 +++++++
 rtl/tap_period_avg.sv | 117 +++++++++++
 tb/tb_tap_period_avg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/taptempo_pkg.sv
// Shared TapTempo definitions: time constants, the measurement FSM encoding
// and a helper that sizes counters from their maximum value.
package taptempo_pkg;

  localparam longint MIN_NS           = 64'd60_000_000_000;
  localparam int     TP_CYCLE_DEFAULT = 5120;
  localparam int     PER_MIN_DEFAULT  = 39062;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } tap_state_t;

  // Bits needed to hold 0..maxVal, i.e. clog2(maxVal+1), never below 1.
  function automatic int widthFor(input longint maxVal);
    int     w;
    longint v;
    w = 0;
    v = maxVal;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/tap_avg_ring.sv
// Moving-average ring for tap intervals: keeps the last AVG_DEPTH samples and
// their running sum, and registers the truncated mean with a one-cycle strobe.
module tap_avg_ring
  import taptempo_pkg::*;
#(
  parameter int W         = 8,
  parameter int AVG_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_sampleValid,
  input  logic [W-1:0] i_sample,
  input  logic         i_invalidate,
  output logic [W-1:0] o_avg,
  output logic         o_avgValid
);

  localparam int L  = $clog2(AVG_DEPTH);
  localparam int PW = (L > 0) ? L : 1;
  localparam int SW = W + L;

  logic [W-1:0]  r_hist [AVG_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [SW-1:0] r_sum;
  logic          r_first;
  logic [W-1:0]  r_avg;
  logic          r_avgValid;
  logic [SW-1:0] w_sumNext;

  // A fresh window behaves as if every slot already held the first sample.
  always_comb begin
    if (r_first) begin
      w_sumNext = SW'(i_sample) << L;
    end else begin
      w_sumNext = r_sum - SW'(r_hist[r_ptr]) + SW'(i_sample);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        r_hist[i] <= '0;
      end
      r_ptr      <= '0;
      r_sum      <= '0;
      r_first    <= 1'b1;
      r_avg      <= '0;
      r_avgValid <= 1'b0;
    end else begin
      r_avgValid <= 1'b0;
      if (i_invalidate) begin
        r_first <= 1'b1;
      end else if (i_sampleValid) begin
        r_sum      <= w_sumNext;
        r_avg      <= W'(w_sumNext >> L);
        r_avgValid <= 1'b1;
        r_first    <= 1'b0;
        if (r_first) begin
          for (int i = 0; i < AVG_DEPTH; i++) begin
            r_hist[i] <= i_sample;
          end
          r_ptr <= '0;
        end else begin
          r_hist[r_ptr] <= i_sample;
          r_ptr         <= (r_ptr == PW'(AVG_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
      end
    end
  end

  assign o_avg      = r_avg;
  assign o_avgValid = r_avgValid;

endmodule

// File: rtl/tap_period_avg.sv
// Tap-period measurement: counts time-base pulses between button rises,
// rejects too-fast taps, times out slow ones and offers the averaged interval.
module tap_period_avg
  import taptempo_pkg::*;
#(
  parameter int     TP_CYCLE  = TP_CYCLE_DEFAULT,
  parameter longint PER_MAX   = MIN_NS / TP_CYCLE,
  parameter int     PER_MIN   = PER_MIN_DEFAULT,
  parameter int     AVG_DEPTH = 4,
  localparam int    W         = widthFor(PER_MAX)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tp_i,
  input  logic         btn_i,
  output logic [W-1:0] per_o,
  output logic         per_valid_o,
  input  logic         per_ready_i,
  output logic         timeout_o,
  output logic         tap_active_o
);

  localparam logic [W-1:0] C_MAX = W'(PER_MAX);
  localparam logic [W-1:0] C_MIN = W'(PER_MIN);

  tap_state_t   r_state;
  tap_state_t   w_stateNext;
  logic [W-1:0] r_count;
  logic [W-1:0] w_countNext;
  logic         r_btnOld;
  logic         r_timeout;
  logic [W-1:0] r_per;
  logic         r_perValid;
  logic         w_rise;
  logic         w_atMax;
  logic         w_sample;
  logic [W-1:0] w_avg;
  logic         w_avgValid;

  assign w_rise = btn_i & ~r_btnOld;

  // Saturation wins over a coincident rise: that rise restarts as a first tap.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_atMax     = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_countNext = '0;
        if (w_rise) begin
          w_stateNext = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (r_count == C_MAX) begin
          w_atMax     = 1'b1;
          w_countNext = '0;
          if (!w_rise) begin
            w_stateNext = ST_IDLE;
          end
        end else if (w_rise && (r_count >= C_MIN)) begin
          w_sample    = 1'b1;
          w_countNext = '0;
        end else if (tp_i) begin
          w_countNext = r_count + 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_countNext = '0;
      end
    endcase
  end

  // btn_old resets high so a button held through reset gives no rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_btnOld   <= 1'b1;
      r_timeout  <= 1'b0;
      r_per      <= '0;
      r_perValid <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_btnOld  <= btn_i;
      r_timeout <= w_atMax;
      if (w_avgValid) begin
        r_per      <= w_avg;
        r_perValid <= 1'b1;
      end else if (per_ready_i) begin
        r_perValid <= 1'b0;
      end
    end
  end

  tap_avg_ring #(
    .W         (W),
    .AVG_DEPTH (AVG_DEPTH)
  ) u_ring (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_sampleValid (w_sample),
    .i_sample      (r_count),
    .i_invalidate  (w_atMax),
    .o_avg         (w_avg),
    .o_avgValid    (w_avgValid)
  );

  assign per_o        = r_per;
  assign per_valid_o  = r_perValid;
  assign timeout_o    = r_timeout;
  assign tap_active_o = (r_state == ST_ARMED);

endmodule

// File: tb/tb_tap_period_avg.sv
// Bench for tap_period_avg: directed and random tap gaps against an interval
// model; a monitor scores every accepted output against a queue of expectations.
module tb_tap_period_avg;

  localparam int PER_MAX   = 100;
  localparam int PER_MIN   = 10;
  localparam int AVG_DEPTH = 4;
  localparam int W         = 7;

  typedef struct {
    int value;
    int due;
    bit exact;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         tp;
  logic         btn;
  logic [W-1:0] perOut;
  logic         perValid;
  logic         perReady;
  logic         timeout;
  logic         tapActive;

  int   assertCount  = 0;
  int   failCount    = 0;
  int   posCount     = 0;
  int   tpPhase      = 0;
  int   sinceRise    = 0;
  int   seenTimeouts = 0;
  bit   lastTimeout  = 1'b0;
  bit   mArmed       = 1'b0;
  bit   mFirst       = 1'b1;
  int   mElapsed     = 0;
  int   mTimeouts    = 0;
  int   mWin[$];
  exp_t expQ[$];

  tap_period_avg #(
    .TP_CYCLE  (5120),
    .PER_MAX   (PER_MAX),
    .PER_MIN   (PER_MIN),
    .AVG_DEPTH (AVG_DEPTH)
  ) dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .tp_i         (tp),
    .btn_i        (btn),
    .per_o        (perOut),
    .per_valid_o  (perValid),
    .per_ready_i  (perReady),
    .timeout_o    (timeout),
    .tap_active_o (tapActive)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) posCount <= posCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock of stimulus; tp fires every third cycle, and a tp landing on a
  // rise is not counted toward the next gap.
  task automatic applyStimulus(input logic btnVal);
    @(negedge clock);
    btn     = btnVal;
    tp      = (tpPhase == 0);
    tpPhase = (tpPhase == 2) ? 0 : tpPhase + 1;
    if (tp && !btnVal) sinceRise++;
  endtask

  task automatic waitTp(input int n);
    int c;
    c = 0;
    while (c < n) begin
      applyStimulus(1'b0);
      if (tp) c++;
    end
  endtask

  // Interval-level model: elapsed pulses since the last accepted tap decide
  // between arm, timeout, ignore and sample; the window is a plain queue.
  task automatic modelTap(input int gap, input int riseCycle);
    int   e;
    int   s;
    exp_t x;
    if (!mArmed) begin
      mArmed   = 1'b1;
      mFirst   = 1'b1;
      mElapsed = 0;
    end else begin
      e = mElapsed + gap;
      if (e >= PER_MAX) begin
        mTimeouts++;
        mFirst   = 1'b1;
        mElapsed = 0;
      end else if (e < PER_MIN) begin
        mElapsed = e;
      end else begin
        if (mFirst) begin
          mWin.delete();
          repeat (AVG_DEPTH) mWin.push_back(e);
          mFirst = 1'b0;
        end else begin
          void'(mWin.pop_front());
          mWin.push_back(e);
        end
        s = 0;
        foreach (mWin[i]) s += mWin[i];
        x.value = s / AVG_DEPTH;
        x.due   = riseCycle + 2;
        x.exact = perReady;
        if (!perReady && expQ.size() > 0) expQ[$] = x;
        else expQ.push_back(x);
        mElapsed = 0;
      end
    end
  endtask

  task automatic tapAfter(input int gap, input bit coincide);
    waitTp(gap);
    if (coincide) begin
      while (tpPhase != 0) applyStimulus(1'b0);
    end
    applyStimulus(1'b1);
    modelTap(sinceRise, posCount);
    sinceRise = 0;
  endtask

  // Monitor: scores every output the consumer accepts and tracks timeout pulses.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        if (lastTimeout) checkOutput("timeout_o pulse width", int'(timeout), 0);
        if (timeout) seenTimeouts++;
        lastTimeout = timeout;
        if (perValid && perReady) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected per_valid_o", int'(perValid), 0);
          end else begin
            x = expQ.pop_front();
            checkOutput("per_o value", int'(perOut), x.value);
            if (x.exact) checkOutput("per_o latency", posCount, x.due);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got 0, expected 1");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  r;
    int  gap;
    bit  co;
    reset    = 1'b1;
    btn      = 1'b1;
    tp       = 1'b0;
    perReady = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) applyStimulus(1'b1);
    checkOutput("reset tap_active_o", int'(tapActive), 0);
    checkOutput("reset per_valid_o", int'(perValid), 0);
    checkOutput("reset per_o", int'(perOut), 0);
    checkOutput("reset timeout_o", int'(timeout), 0);
    sinceRise = 0;

    tapAfter(1, 1'b0);
    applyStimulus(1'b0);
    checkOutput("armed tap_active_o", int'(tapActive), 1);
    tapAfter(40, 1'b0);
    tapAfter(40, 1'b0);
    tapAfter(20, 1'b0);
    tapAfter(20, 1'b0);

    tapAfter(5, 1'b0);
    tapAfter(35, 1'b0);

    waitTp(110);
    checkOutput("timeout tap_active_o", int'(tapActive), 0);
    checkOutput("timeout pulses so far", seenTimeouts, 1);
    tapAfter(3, 1'b0);
    tapAfter(30, 1'b0);

    perReady = 1'b0;
    tapAfter(40, 1'b0);
    tapAfter(20, 1'b0);
    repeat (3) applyStimulus(1'b0);
    checkOutput("held per_valid_o", int'(perValid), 1);
    if (expQ.size() > 0) checkOutput("held per_o", int'(perOut), expQ[$].value);
    perReady = 1'b1;
    applyStimulus(1'b0);
    checkOutput("per_valid_o after ready", int'(perValid), 0);

    tapAfter(39, 1'b1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) gap = $urandom_range(1, 9);
      else if (r == 9) gap = $urandom_range(100, 130);
      else gap = $urandom_range(10, 99);
      co = ($urandom_range(0, 3) == 0) && mArmed && !mFirst &&
           (mElapsed + gap >= PER_MIN) && (mElapsed + gap < PER_MAX);
      tapAfter(gap, co);
    end

    repeat (10) applyStimulus(1'b0);
    checkOutput("timeout pulse count", seenTimeouts, mTimeouts);
    checkOutput("outputs still expected", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
